// File: rtl/key_expand_128.sv
// key_expand_128: iterative AES-128 key expansion using an external SubWord unit
// Ports: clk/reset (async active-low); start+key_in begin an expansion;
// sw_valid_out/sw_data_out request SubWord(RotWord(w3)), sw_valid_in/sw_data_in
// return it; rk_valid/rk_round/rk_data present each round key; busy, done, err
// report status. Macro KEY_EXPAND_TIMEOUT_EN adds a 16-cycle WAIT watchdog
// driving err; without it err is tied low.
module key_expand_128 #(
  parameter int DATA_LEN   = 32,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DATA_LEN-1:0] key_in,
  output logic                  sw_valid_out,
  output logic [DATA_LEN-1:0]   sw_data_out,
  input  logic                  sw_valid_in,
  input  logic [DATA_LEN-1:0]   sw_data_in,
  output logic                  rk_valid,
  output logic [3:0]            rk_round,
  output logic [4*DATA_LEN-1:0] rk_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int W = DATA_LEN;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t         state_q;
  logic [4*W-1:0] key_q, key_d;
  logic [W-1:0]   t_d, w0_d, w1_d, w2_d, w3_d, sw_data_q;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     round_q;
  logic           sw_valid_q, rk_valid_q, busy_q, done_q, last_d;

  function automatic logic [W-1:0] rot_word(input logic [W-1:0] x);
    return {x[W-9:0], x[W-1:W-8]};
  endfunction

  // Next round key: each new word chains off the previously computed new word.
  always_comb begin
    t_d    = sw_data_in ^ {rcon_q, {(W-8){1'b0}}};
    w0_d   = key_q[4*W-1:3*W] ^ t_d;
    w1_d   = key_q[3*W-1:2*W] ^ w0_d;
    w2_d   = key_q[2*W-1:W] ^ w1_d;
    w3_d   = key_q[W-1:0] ^ w2_d;
    key_d  = {w0_d, w1_d, w2_d, w3_d};
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    last_d = round_q == 4'(NUM_ROUNDS - 1);
  end

`ifdef KEY_EXPAND_TIMEOUT_EN
  logic [3:0] timer_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      rcon_q     <= '0;
      round_q    <= '0;
      sw_valid_q <= 1'b0;
      sw_data_q  <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef KEY_EXPAND_TIMEOUT_EN
      timer_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      sw_valid_q <= 1'b0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef KEY_EXPAND_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        IDLE: if (start) begin
          key_q      <= key_in;
          round_q    <= '0;
          rcon_q     <= 8'h01;
          rk_valid_q <= 1'b1;
          busy_q     <= 1'b1;
          sw_valid_q <= 1'b1;
          sw_data_q  <= rot_word(key_in[W-1:0]);
          state_q    <= REQ;
        end
        REQ: begin
          state_q <= WAIT;
`ifdef KEY_EXPAND_TIMEOUT_EN
          timer_q <= '0;
`endif
        end
        WAIT: if (sw_valid_in) begin
          key_q      <= key_d;
          rcon_q     <= rcon_d;
          round_q    <= round_q + 4'd1;
          rk_valid_q <= 1'b1;
          busy_q     <= !last_d;
          done_q     <= last_d;
          sw_valid_q <= !last_d;
          sw_data_q  <= rot_word(w3_d);
          state_q    <= last_d ? IDLE : REQ;
        end
`ifdef KEY_EXPAND_TIMEOUT_EN
        else if (timer_q == 4'hf) begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else timer_q <= timer_q + 4'd1;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_valid_out = sw_valid_q;
  assign sw_data_out  = sw_data_q;
  assign rk_valid     = rk_valid_q;
  assign rk_round     = round_q;
  assign rk_data      = key_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_key_expand_128.sv
// tb_key_expand_128: randomized self-checking bench against an AES key schedule model
module tb_key_expand_128;
  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [127:0] key_in = '0;
  logic         sw_valid_out, sw_valid_in, rk_valid, busy, done, err;
  logic [31:0]  sw_data_out, sw_data_in;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;

  key_expand_128 dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .sw_valid_out(sw_valid_out), .sw_data_out(sw_data_out),
    .sw_valid_in(sw_valid_in), .sw_data_in(sw_data_in),
    .rk_valid(rk_valid), .rk_round(rk_round), .rk_data(rk_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, s_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse (a^254) then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01, b, s;
    repeat (254) inv = gmul(inv, a);
    b = inv;
    s = inv;
    for (int i = 0; i < 4; i++) begin
      b = {b[6:0], b[7]};
      s = s ^ b;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  logic [7:0]   rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_k  [11];

  function automatic void ref_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subword({t[23:0], t[31:24]}) ^ {rc_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // SubWord responder with programmable latency; spur injects stray valids.
  bit          sw_en = 1'b1, spur = 1'b0;
  int          sw_lat = 1, cnt = 0;
  logic        model_v = 1'b0;
  logic [31:0] pend = '0;
  assign sw_valid_in = model_v | spur;
  assign sw_data_in  = pend;

  always @(posedge clk) begin
    if (!reset) begin
      cnt     <= 0;
      model_v <= 1'b0;
      pend    <= '0;
    end else begin
      model_v <= 1'b0;
      if (sw_en && sw_valid_out) begin
        pend <= subword(sw_data_out);
        if (sw_lat == 1) model_v <= 1'b1;
        else cnt <= sw_lat - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) model_v <= 1'b1;
      end
    end
  end

  typedef struct {int c; logic [3:0] r; logic [127:0] d; logic b;} rk_t;
  rk_t          rk_q [$];
  int           done_n = 0, err_n = 0, swv_n = 0, done_c = 0, err_c = 0, stab_bad = 0;
  logic [131:0] last = '0;

  always @(negedge clk) begin
    if (rk_valid) rk_q.push_back('{cyc, rk_round, rk_data, busy});
    if (done) begin done_n++; done_c = cyc; end
    if (err) begin err_n++; err_c = cyc; end
    if (sw_valid_out) swv_n++;
    if (!reset) last = '0;
    else if (rk_valid) last = {rk_round, rk_data};
    else if ({rk_round, rk_data} !== last) stab_bad++;
  end

  task automatic clear_mon();
    rk_q.delete();
    done_n = 0; err_n = 0; swv_n = 0; stab_bad = 0;
  endtask

  task automatic kick(input logic [127:0] k);
    @(negedge clk);
    clear_mon();
    start = 1'b1; key_in = k; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit to);
    for (int i = 0; i < budget && done_n == 0 && err_n == 0; i++) @(negedge clk);
    to = (done_n == 0 && err_n == 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if ({rk_valid, rk_round, rk_data} !== '0) begin n_fail++; $display("FAIL reset_rk: got %h required 0", {rk_valid, rk_round, rk_data}); end
    n_chk++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b required 000", {busy, done, err}); end
    n_chk++; if ({sw_valid_out, sw_data_out} !== '0) begin n_fail++; $display("FAIL reset_sw: got %h required 0", {sw_valid_out, sw_data_out}); end
    #2 reset = 1'b1;
  endtask

  task automatic test_fips();
    bit to;
    logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    sw_lat = 1;
    ref_expand(k);
    kick(k);
    wait_end(100, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL fips_timeout: got no done, required done"); end
    n_chk++; if (rk_q.size() != 11) begin n_fail++; $display("FAIL fips_count: got %0d required 11", rk_q.size()); end
    for (int r = 0; r < rk_q.size(); r++) begin
      n_chk++; if (rk_q[r].d !== exp_k[r] || rk_q[r].r !== 4'(r)) begin n_fail++; $display("FAIL fips_key%0d: got %0d/%h required %0d/%h", r, rk_q[r].r, rk_q[r].d, r, exp_k[r]); end
      n_chk++; if (rk_q[r].c - s_cyc != 1 + 2*r) begin n_fail++; $display("FAIL fips_cycle%0d: got %0d required %0d", r, rk_q[r].c - s_cyc, 1 + 2*r); end
      n_chk++; if (rk_q[r].b !== (r != 10)) begin n_fail++; $display("FAIL fips_busy%0d: got %b required %b", r, rk_q[r].b, r != 10); end
    end
    if (rk_q.size() == 11) begin
      n_chk++; if (rk_q[1].d !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL fips_round1: got %h required a0fafe1788542cb123a339392a6c7605", rk_q[1].d); end
      n_chk++; if (rk_q[10].d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL fips_round10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", rk_q[10].d); end
    end
    n_chk++; if (done_n != 1 || done_c - s_cyc != 21) begin n_fail++; $display("FAIL fips_done: got %0d pulses at %0d required 1 at 21", done_n, done_c - s_cyc); end
    n_chk++; if (swv_n != 10) begin n_fail++; $display("FAIL fips_sw_reqs: got %0d required 10", swv_n); end
    n_chk++; if (stab_bad != 0) begin n_fail++; $display("FAIL fips_stable: got %0d changes required 0", stab_bad); end
  endtask

  task automatic test_stall();
    bit to;
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    sw_lat = 5;
    ref_expand(k);
    kick(k);
    wait_end(200, to);
    n_chk++; if (to || rk_q.size() != 11) begin n_fail++; $display("FAIL stall_count: got %0d keys required 11", rk_q.size()); end
    for (int r = 0; r < rk_q.size(); r++) begin
      n_chk++; if (rk_q[r].d !== exp_k[r]) begin n_fail++; $display("FAIL stall_key%0d: got %h required %h", r, rk_q[r].d, exp_k[r]); end
      if (r > 0) begin
        n_chk++; if (rk_q[r].c - rk_q[r-1].c != 6) begin n_fail++; $display("FAIL stall_spacing%0d: got %0d required 6", r, rk_q[r].c - rk_q[r-1].c); end
      end
    end
    n_chk++; if (swv_n != 10 || done_n != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d reqs %0d done required 10 reqs 1 done", swv_n, done_n); end
    sw_lat = 1;
  endtask

  task automatic test_spurious();
    bit to, sent_start = 0, sent_spur = 0;
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    ref_expand(k);
    @(negedge clk);
    clear_mon();
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    n_chk++; if (rk_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_spur: got %0d keys busy %b required 0 keys busy 0", rk_q.size(), busy); end
    kick(k);
    for (int i = 0; i < 60 && done_n == 0; i++) begin
      start = 1'b0; spur = 1'b0;
      if (rk_valid && rk_round == 4'd4 && !sent_start) begin start = 1'b1; key_in = ~k; sent_start = 1; end
      if (sw_valid_out && !sent_spur) begin spur = 1'b1; sent_spur = 1; end
      @(negedge clk);
    end
    start = 1'b0; spur = 1'b0;
    wait_end(10, to);
    n_chk++; if (to || rk_q.size() != 11) begin n_fail++; $display("FAIL spur_count: got %0d keys required 11", rk_q.size()); end
    for (int r = 0; r < rk_q.size(); r++) begin
      n_chk++; if (rk_q[r].d !== exp_k[r] || rk_q[r].c - s_cyc != 1 + 2*r) begin n_fail++; $display("FAIL spur_key%0d: got %h at %0d required %h at %0d", r, rk_q[r].d, rk_q[r].c - s_cyc, exp_k[r], 1 + 2*r); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
    kick(k);
    for (int i = 0; i < 40 && !(rk_valid && rk_round == 4'd6); i++) @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_chk++; if ({sw_valid_out, sw_data_out, rk_valid, rk_round, rk_data, busy, done, err} !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h required 0", {sw_valid_out, sw_data_out, rk_valid, rk_round, rk_data, busy, done, err}); end
    ref_expand(k2);
    @(negedge clk);
    #2;
    clear_mon();
    reset = 1'b1; start = 1'b1; key_in = k2; s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_end(100, to);
    n_chk++; if (to || rk_q.size() != 11) begin n_fail++; $display("FAIL midreset_count: got %0d keys required 11", rk_q.size()); end
    if (rk_q.size() > 0) begin
      n_chk++; if (rk_q[0].d !== k2 || rk_q[0].c - s_cyc != 1) begin n_fail++; $display("FAIL midreset_round0: got %h at %0d required %h at 1", rk_q[0].d, rk_q[0].c - s_cyc, k2); end
    end
    for (int r = 1; r < rk_q.size(); r++) begin
      n_chk++; if (rk_q[r].d !== exp_k[r]) begin n_fail++; $display("FAIL midreset_key%0d: got %h required %h", r, rk_q[r].d, exp_k[r]); end
    end
  endtask

  task automatic test_timeout();
    bit to;
    sw_en = 1'b0;
    kick({$urandom, $urandom, $urandom, $urandom});
`ifdef KEY_EXPAND_TIMEOUT_EN
    wait_end(40, to);
    n_chk++; if (to || err_n != 1 || err_c - s_cyc != 18) begin n_fail++; $display("FAIL timeout_err: got %0d pulses at %0d required 1 at 18", err_n, err_c - s_cyc); end
    repeat (10) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || done_n != 0 || rk_q.size() != 1) begin n_fail++; $display("FAIL timeout_after: got busy %b done %0d keys %0d required 0 0 1", busy, done_n, rk_q.size()); end
`else
    wait_end(40, to);
    n_chk++; if (busy !== 1'b1 || err_n != 0 || done_n != 0 || rk_q.size() != 1) begin n_fail++; $display("FAIL no_timeout: got busy %b err %0d done %0d keys %0d required 1 0 0 1", busy, err_n, done_n, rk_q.size()); end
`endif
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    sw_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_stall();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/key_expand_128.md
KEY_EXPAND_128 -- requirements
Module: key_expand_128

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: word width, SubWord interface width.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10: number of round keys after round 0.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to expand key_in.
REQ-006 SHALL have port key_in  input  128  cipher key; w0 = key_in[127:96], w3 = key_in[31:0].
REQ-007 SHALL have port sw_valid_out  output  1  request to downstream SubWord (drives its valid_in).
REQ-008 SHALL have port sw_data_out  output  32  RotWord(w3) to SubWord data_in.
REQ-009 SHALL have port sw_valid_in  input  1  SubWord valid_out.
REQ-010 SHALL have port sw_data_in  input  32  SubWord data_out.
REQ-011 SHALL have port rk_valid  output  1  round key valid, one-cycle pulse per round.
REQ-012 SHALL have port rk_round  output  4  round index 0..NUM_ROUNDS of rk_data.
REQ-013 SHALL have port rk_data  output  128  round key, same word order as key_in.
REQ-014 SHALL have ports busy  output  1  (expansion in progress), done  output  1  (completion pulse), err  output  1  (timeout pulse).

Function
REQ-015 SHALL implement FSM IDLE, REQ, WAIT; all outputs registered or decoded from state registers only.
REQ-016 SHALL, in IDLE on start=1, register key_in, set round counter 0, rcon 0x01, go REQ; rk_valid=1, rk_round=0, rk_data=key_in the next cycle.
REQ-017 SHALL ignore start whenever state is not IDLE.
REQ-018 SHALL, in REQ, assert sw_valid_out for exactly one cycle with sw_data_out = {w3[23:0], w3[31:24]}, then go WAIT.
REQ-019 SHALL, in WAIT, hold sw_valid_out=0 and wait any number of cycles for sw_valid_in=1; sw_valid_in outside WAIT SHALL be ignored.
REQ-020 SHALL, on sw_valid_in in WAIT, compute t = sw_data_in XOR {rcon,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; register, increment round, next cycle pulse rk_valid with new round.
REQ-021 SHALL update rcon per round by GF(2^8) xtime: shift left 1, XOR 0x1B if bit7 was set (0x01..0x80, 0x1B, 0x36).
REQ-022 SHALL go REQ after rounds 1..NUM_ROUNDS-1; after round NUM_ROUNDS go IDLE and pulse done in the same cycle as that rk_valid.
REQ-023 SHALL hold busy=1 from the cycle after accepted start through the final rk_valid cycle exclusive; busy=0 in that final cycle.
REQ-024 SHALL hold rk_data/rk_round stable between rk_valid pulses.
REQ-025 SHALL, with 1-cycle SubWord latency, emit round r at cycle 1+2r after the start edge (round 10 at cycle 21).

Reset
REQ-026 SHALL, on reset=0 at any time including mid-expansion, asynchronously force IDLE and clear sw_valid_out, sw_data_out, rk_valid, rk_round, rk_data, busy, done, err, counters and rcon to 0.
REQ-027 SHALL accept a new start on the first clock edge after reset deasserts.

Configuration
REQ-028 SHALL with macro KEY_EXPAND_TIMEOUT_EN defined include a 4-bit WAIT watchdog: 16 cycles in WAIT without sw_valid_in pulse err for one cycle, return IDLE, no done, no further rk_valid.
REQ-029 SHALL without KEY_EXPAND_TIMEOUT_EN wait indefinitely in WAIT and tie err to 0.

Verification
REQ-030 SHALL cover FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with 1-cycle SubWord model -> round1 a0fafe1788542cb123a339392a6c7605, round10 d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 21, done with it.
REQ-031 SHALL cover SubWord model stalling 5 cycles per request -> identical 11 keys, one sw_valid_out pulse per round, round spacing 6 cycles.
REQ-032 SHALL cover start pulsed again during round 4 and spurious sw_valid_in in IDLE/REQ -> no effect, same key sequence.
REQ-033 SHALL cover reset asserted during round 6 WAIT -> all outputs 0 immediately; fresh start yields round0 = new key.
REQ-034 SHALL cover, with KEY_EXPAND_TIMEOUT_EN, SubWord never answering -> err pulse 16 cycles after entering WAIT, busy 0, no done; without macro, busy stays 1.
